// File: rtl/iir_pkg.sv
// Shared types and constants for the biquad coefficient-update controller.
// Coefficients are s16,14; bank order is scale, b1, b2, b3, a2, a3.
package iir_pkg;

    localparam int COEFF_W = 16;
    localparam int N_COEFF = 6;

    localparam int IDX_SCALE = 0;
    localparam int IDX_B1    = 1;
    localparam int IDX_B2    = 2;
    localparam int IDX_B3    = 3;
    localparam int IDX_A2    = 4;
    localparam int IDX_A3    = 5;

    localparam int Q14_ONE = 16384;

    typedef logic signed [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CLEAR,
        DONE
    } state_e;

endpackage

// File: rtl/iir_stab_check.sv
// Stability-triangle test on the shadow denominator, 18-bit signed Q14.
// Only instantiated when IIR_CTRL_STAB_CHECK_EN is defined.
module iir_stab_check
    import iir_pkg::*;
(
    input  coeff_t a2,
    input  coeff_t a3,
    output logic   stable
);

    localparam logic signed [17:0] ONE_X = 18'sd16384;

    logic signed [17:0] a2_x;
    logic signed [17:0] a3_x;
    logic signed [17:0] a2_abs;
    logic signed [17:0] a3_abs;
    logic signed [17:0] lim;

    always_comb begin
        a2_x   = {{2{a2[COEFF_W-1]}}, a2};
        a3_x   = {{2{a3[COEFF_W-1]}}, a3};
        a2_abs = a2_x[17] ? -a2_x : a2_x;
        a3_abs = a3_x[17] ? -a3_x : a3_x;
        lim    = ONE_X + a3_x;
        stable = (a3_abs < ONE_X) && (a2_abs < lim);
    end

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Shadow/active coefficient banks with sample-aligned swap and clk_enable gating.
// Define IIR_CTRL_STAB_CHECK_EN to reject commits of an unstable denominator.
module iir_coeff_ctrl
    import iir_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TMR_W   = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               commit,
    input  logic               commit_clear,
    input  logic               sample_en,
    output logic               filter_enable,
    output logic               filter_clear,
    output logic [COEFF_W-1:0] scale_out,
    output logic [COEFF_W-1:0] b1_out,
    output logic [COEFF_W-1:0] b2_out,
    output logic [COEFF_W-1:0] b3_out,
    output logic [COEFF_W-1:0] a2_out,
    output logic [COEFF_W-1:0] a3_out,
    output logic               busy,
    output logic               commit_done,
    output logic               wr_err,
    output logic               commit_err
);

    localparam logic [2:0]       N_ADDR   = 3'(N_COEFF);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              clr_q, clr_d;
    logic              busy_q, busy_d;
    logic              wr_err_q, wr_err_d;
    logic              commit_err_q, commit_err_d;
    coeff_t            shadow_q [N_COEFF];
    coeff_t            shadow_d [N_COEFF];
    coeff_t            active_q [N_COEFF];
    coeff_t            active_d [N_COEFF];

    logic accept;
    logic wr_ok;
    logic stab_ok;

    // Host access only in a true idle cycle; the cycle after DONE still counts as busy.
    assign accept = (state_q == IDLE) && !busy_q;
    assign wr_ok  = wr_addr < N_ADDR;

    always_comb begin
        shadow_d = shadow_q;
        wr_err_d = 1'b0;
        if (wr_en) begin
            if (accept && wr_ok) begin
                shadow_d[wr_addr] = wr_data;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

`ifdef IIR_CTRL_STAB_CHECK_EN
    iir_stab_check u_stab (
        .a2     (shadow_d[IDX_A2]),
        .a3     (shadow_d[IDX_A3]),
        .stable (stab_ok)
    );
`else
    assign stab_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        clr_d         = clr_q;
        active_d      = active_q;
        commit_err_d  = 1'b0;
        filter_enable = 1'b0;
        filter_clear  = 1'b0;
        commit_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                filter_enable = sample_en;
                if (commit && accept) begin
                    if (stab_ok) begin
                        clr_d   = commit_clear;
                        tmr_d   = '0;
                        state_d = ARMED;
                    end else begin
                        commit_err_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                tmr_d = tmr_q + 1'b1;
                if (sample_en) begin
                    active_d = shadow_q;
                    state_d  = clr_q ? CLEAR : DONE;
                end else if (tmr_q == TMR_LAST) begin
                    active_d = shadow_q;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                filter_clear = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                commit_done   = 1'b1;
                filter_enable = sample_en;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        filter_enable = filter_enable & reset_n;
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            wr_err_q     <= 1'b0;
            commit_err_q <= 1'b0;
            shadow_q     <= '{default: '0};
            active_q     <= '{default: '0};
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            clr_q        <= clr_d;
            busy_q       <= busy_d;
            wr_err_q     <= wr_err_d;
            commit_err_q <= commit_err_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    assign scale_out  = active_q[IDX_SCALE];
    assign b1_out     = active_q[IDX_B1];
    assign b2_out     = active_q[IDX_B2];
    assign b3_out     = active_q[IDX_B3];
    assign a2_out     = active_q[IDX_A2];
    assign a3_out     = active_q[IDX_A3];
    assign busy       = busy_q;
    assign wr_err     = wr_err_q;
    assign commit_err = commit_err_q;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Directed self-checking bench for iir_coeff_ctrl.
// Honours IIR_CTRL_STAB_CHECK_EN for the commit-rejection checks.
module tb_iir_coeff_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit;
    logic        commit_clear;
    logic        sample_en;
    logic        filter_enable;
    logic        filter_clear;
    logic [15:0] scale_out, b1_out, b2_out, b3_out, a2_out, a3_out;
    logic        busy;
    logic        commit_done;
    logic        wr_err;
    logic        commit_err;

    int n_cmp = 0;
    int n_bad = 0;

    iir_coeff_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .commit_clear  (commit_clear),
        .sample_en     (sample_en),
        .filter_enable (filter_enable),
        .filter_clear  (filter_clear),
        .scale_out     (scale_out),
        .b1_out        (b1_out),
        .b2_out        (b2_out),
        .b3_out        (b3_out),
        .a2_out        (a2_out),
        .a3_out        (a3_out),
        .busy          (busy),
        .commit_done   (commit_done),
        .wr_err        (wr_err),
        .commit_err    (commit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    logic [15:0] vals [6];

    initial begin
        vals = '{16'h015C, 16'h4000, 16'h0000, 16'hC000, 16'h82E6, 16'h3D47};
        reset_n      = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        commit       = 1'b0;
        commit_clear = 1'b0;
        sample_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fe", filter_enable, 0);
        chk("rst_fc", filter_clear, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", commit_done, 0);
        chk("rst_wrerr", wr_err, 0);
        chk("rst_cerr", commit_err, 0);
        chk("rst_scale", scale_out, 0);
        chk("rst_a3", a3_out, 0);
        reset_n = 1'b1;
        tick();

        // load bank, commit without clear, sample five cycles after commit
        for (int i = 0; i < 6; i++) begin
            wr(3'(i), vals[i]);
            chk("wr_ok_noerr", wr_err, 0);
        end
        chk("pre_commit_scale", scale_out, 0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t1_busy", busy, 1);
        repeat (4) tick();
        chk("t1_hold_scale", scale_out, 0);
        chk("t1_hold_fc", filter_clear, 0);
        sample_en = 1'b1;
        #1;
        chk("t1_drop_fe", filter_enable, 0);
        tick();
        sample_en = 1'b0;
        chk("t1_scale", scale_out, 16'h015C);
        chk("t1_b1", b1_out, 16'h4000);
        chk("t1_b2", b2_out, 16'h0000);
        chk("t1_b3", b3_out, 16'hC000);
        chk("t1_a2", a2_out, 16'h82E6);
        chk("t1_a3", a3_out, 16'h3D47);
        chk("t1_done", commit_done, 1);
        chk("t1_fc", filter_clear, 0);
        tick();
        chk("t1_done_end", commit_done, 0);
        chk("t1_busy_tail", busy, 1);
        tick();
        chk("t1_busy_off", busy, 0);

        // commit with clear, sample on the cycle after commit
        wr(3'd0, 16'h1234);
        commit       = 1'b1;
        commit_clear = 1'b1;
        tick();
        commit       = 1'b0;
        commit_clear = 1'b0;
        sample_en    = 1'b1;
        #1;
        chk("t2_busy1", busy, 1);
        chk("t2_drop_fe", filter_enable, 0);
        chk("t2_fc_pre", filter_clear, 0);
        tick();
        sample_en = 1'b0;
        chk("t2_fc", filter_clear, 1);
        chk("t2_scale", scale_out, 16'h1234);
        chk("t2_done_early", commit_done, 0);
        chk("t2_busy2", busy, 1);
        tick();
        chk("t2_fc_end", filter_clear, 0);
        chk("t2_done", commit_done, 1);
        chk("t2_busy3", busy, 1);
        tick();
        chk("t2_busy4", busy, 1);
        tick();
        chk("t2_busy_off", busy, 0);

        // timeout-forced swap always clears
        wr(3'd0, 16'h0777);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (1023) tick();
        chk("t3_hold_scale", scale_out, 16'h1234);
        chk("t3_hold_fc", filter_clear, 0);
        chk("t3_hold_busy", busy, 1);
        tick();
        chk("t3_fc", filter_clear, 1);
        chk("t3_scale", scale_out, 16'h0777);
        tick();
        chk("t3_done", commit_done, 1);
        repeat (2) tick();

        // rejected writes
        wr_en   = 1'b1;
        wr_addr = 3'd6;
        wr_data = 16'h7FFF;
        tick();
        wr_en = 1'b0;
        chk("t4_addr_err", wr_err, 1);
        tick();
        chk("t4_err_pulse", wr_err, 0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr(3'd0, 16'h5555);
        chk("t4_busy_err", wr_err, 1);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("t4_scale_kept", scale_out, 16'h0777);
        chk("t4_done", commit_done, 1);
        commit = 1'b1;
        tick();
        chk("t4_tail_busy", busy, 1);
        tick();
        commit = 1'b0;
        chk("t4_commit_ignored", busy, 0);
        chk("t4_no_cerr", commit_err, 0);

        // write and commit in the same cycle
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 16'h2000;
        commit  = 1'b1;
        tick();
        wr_en     = 1'b0;
        commit    = 1'b0;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("t5_b1_same_cycle", b1_out, 16'h2000);
        chk("t5_scale_shadow", scale_out, 16'h0777);
        repeat (2) tick();

`ifdef IIR_CTRL_STAB_CHECK_EN
        wr(3'd5, 16'h4000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("s_cerr", commit_err, 1);
        chk("s_rej_busy", busy, 0);
        chk("s_rej_a3", a3_out, 16'h3D47);
        tick();
        chk("s_cerr_pulse", commit_err, 0);
        wr(3'd5, 16'h3D47);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("s_acc_busy", busy, 1);
        chk("s_acc_cerr", commit_err, 0);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("s_acc_done", commit_done, 1);
        chk("s_acc_a2", a2_out, 16'h82E6);
        repeat (2) tick();
`else
        wr(3'd5, 16'h4000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("n_cerr", commit_err, 0);
        chk("n_busy", busy, 1);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("n_a3", a3_out, 16'h4000);
        repeat (2) tick();
`endif

        // reset during ARMED
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("r_armed", busy, 1);
        #2;
        reset_n   = 1'b0;
        sample_en = 1'b1;
        #1;
        chk("r_busy", busy, 0);
        chk("r_fe", filter_enable, 0);
        chk("r_scale", scale_out, 0);
        chk("r_b1", b1_out, 0);
        chk("r_done", commit_done, 0);
        chk("r_fc", filter_clear, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("r_pass_fe", filter_enable, 1);
        sample_en = 1'b0;
        tick();
        commit = 1'b1;
        tick();
        commit    = 1'b0;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("r_done2", commit_done, 1);
        chk("r_zero_b1", b1_out, 0);
        chk("r_zero_a2", a2_out, 0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
